// File: rtl/sync_tx_feeder_pkg.sv
// Shared definitions for the transmit-side feeder of the 4-phase synchronizer.
// Holds the data width, the FSM state encoding and the default phase timeout.
package sync_tx_feeder_pkg;

   localparam int DATA_MSB        = 31;
   localparam int TIMEOUT_DEFAULT = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      REL  = 2'd2
   } state_t;

endpackage

// File: rtl/sync_tx_fifo.sv
// Single-clock show-ahead FIFO; push lands after 1 edge, head is visible combinationally.
// Backpressure: full is registered, a push while full is dropped even with a concurrent pop.
module sync_tx_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pop,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic [CNT_W-1:0]  level
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  level_nxt;
   logic              do_push;
   logic              do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && (level != '0);
   assign rd_data = mem[rd_ptr];

   always_comb begin
      level_nxt = level;
      if (do_push && !do_pop)
         level_nxt = level + CNT_W'(1);
      else if (!do_push && do_pop)
         level_nxt = level - CNT_W'(1);
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         level <= level_nxt;
         full  <= (level_nxt == CNT_W'(DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/sync_tx_feeder.sv
// Buffers core words and drives the synchronizer with a 4-phase vi/snt handshake; optional timeout via SYNC_TX_TIMEOUT_EN.
// Latency: push at edge N into an idle, empty feeder gives vi=1 with valid indata after edge N+1.
// Backpressure: core sees only full/level; the handshake never stalls the push side.
module sync_tx_feeder
   import sync_tx_feeder_pkg::*;
#(
   parameter int DATA_W  = DATA_MSB + 1,
   parameter int DEPTH   = 4,
   parameter int CNT_W   = $clog2(DEPTH) + 1,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic              clk_tx,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic              full,
   output logic [CNT_W-1:0]  level,
   output logic [DATA_W-1:0] indata,
   output logic              vi,
   input  logic              snt,
   output logic              busy,
   output logic              err
);

   state_t            state;
   logic [DATA_W-1:0] head;
   logic              launch;

   // A stale acknowledge (snt still high) holds off the next launch.
   assign launch = (state == IDLE) && (level != '0) && !snt;
   assign busy   = (state != IDLE) || (level != '0);

   sync_tx_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) u_fifo (
      .clk     (clk_tx),
      .rst_n   (reset),
      .push    (wr_en),
      .wr_data (wr_data),
      .pop     (launch),
      .rd_data (head),
      .full    (full),
      .level   (level)
   );

   always_ff @(posedge clk_tx or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         vi     <= 1'b0;
         indata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (launch) begin
                  state  <= REQ;
                  vi     <= 1'b1;
                  indata <= head;
               end
            end
            REQ: begin
               if (snt) begin
                  state <= REL;
                  vi    <= 1'b0;
               end
            end
            REL: begin
               if (!snt)
                  state <= IDLE;
            end
            default: begin
               state <= IDLE;
               vi    <= 1'b0;
            end
         endcase
      end
   end

`ifdef SYNC_TX_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   logic [TMO_W-1:0] phase_cnt;
   logic             state_chg;

   assign state_chg = launch || ((state == REQ) && snt) || ((state == REL) && !snt);

   // Counts edges spent in the current REQ/REL phase; err fires on the edge it hits TIMEOUT.
   always_ff @(posedge clk_tx or negedge reset) begin
      if (!reset) begin
         phase_cnt <= '0;
         err       <= 1'b0;
      end else if (state_chg) begin
         phase_cnt <= '0;
      end else if ((state != IDLE) && (phase_cnt != TMO_W'(TIMEOUT))) begin
         phase_cnt <= phase_cnt + TMO_W'(1);
         if (phase_cnt == TMO_W'(TIMEOUT - 1))
            err <= 1'b1;
      end
   end
`else
   logic unused_timeout;

   assign unused_timeout = ^TIMEOUT;
   assign err            = 1'b0;
`endif

endmodule

// File: doc/sync_tx_feeder.md
Name: sync_tx_feeder

Overview:
- Transmit-side source stage sitting directly upstream of the two-flop 4-phase synchronizer (`sync`) in the clk_tx domain.
- Buffers core data words in a small FIFO and drives the synchronizer's `indata`/`vi` request with a full 4-phase handshake, closed by the synchronizer's `snt` acknowledge.
- Presents a simple push interface to the core: a write strobe with a full flag, never a stall on the handshake itself.

Parameters:
- DATA_W, 32, data word width; equals DATA_MSB+1 from the shared definitions.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 3, width of `level`; equals log2(DEPTH)+1.
- TIMEOUT, 64, clk_tx cycles allowed per handshake phase; used only with the optional feature.

Ports:
- clk_tx  in  1  transmit-domain clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  core push strobe.
- wr_data  in  DATA_W  core data word.
- full  out  1  FIFO full; a push while full is dropped.
- level  out  CNT_W  FIFO occupancy, 0..DEPTH.
- indata  out  DATA_W  word to the synchronizer; registered.
- vi  out  1  4-phase request to the synchronizer; registered.
- snt  in  1  4-phase acknowledge from the synchronizer, already synchronous to clk_tx.
- busy  out  1  high when the FSM is not in IDLE or `level` is nonzero.
- err  out  1  sticky handshake timeout; tied 0 without the optional feature.

Behaviour:
- Reset (reset=0) clears everything immediately, independent of the clock:
  - vi=0, indata=0, level=0, full=0, busy=0, err=0.
  - FSM goes to IDLE; read and write pointers go to 0.
- FIFO:
  - A push with wr_en=1 and full=0 stores wr_data at the write pointer; the pointer increments and wraps modulo DEPTH.
  - A push with wr_en=1 and full=1 is ignored. No state changes, including when a pop occurs in the same cycle.
  - Push and pop in the same cycle leave `level` unchanged.
  - full = (level==DEPTH); both full and level are registered.
- FSM, states IDLE, REQ, REL:
  - IDLE -> REQ when level!=0 and snt=0. On that edge the head word is popped into `indata` and vi goes to 1.
  - REQ: vi=1, `indata` held stable. Go to REL on the first edge with snt=1; on that edge vi goes to 0.
  - REL: vi=0, `indata` still held. Go to IDLE on the first edge with snt=0.
  - A stale snt=1 while in IDLE blocks launch until snt returns to 0.
  - `indata` changes only on the IDLE->REQ edge.
- Latency:
  - Push at edge N into an empty FIFO with the FSM in IDLE and snt=0: the FIFO holds the word after edge N, and vi=1 with valid `indata` after edge N+1.
  - Minimum handshake is 2 cycles plus the synchronizer's acknowledge delays. Back-to-back words need a new REQ only after REL has completed.
- Ordering: words reach the synchronizer strictly in FIFO order, and none are lost unless pushed while full.
- Reset mid-handshake: vi drops asynchronously and the FIFO content is discarded. After reset the FSM waits for snt=0 before the next launch.

Optional Feature:
- Macro: SYNC_TX_TIMEOUT_EN.
- With the macro:
  - A phase counter clears on every state change and counts clk_tx cycles spent in REQ or REL.
  - When it reaches TIMEOUT, err is set and stays set until reset. The FSM keeps waiting, and the counter saturates.
- Without the macro: no counter is built and err is a constant 0.

Decomposition:
- The shared definitions include holds DATA_MSB, the IDLE/REQ/REL state encoding (2-bit) and the default TIMEOUT.
- One sub-module, `sync_tx_fifo`:
  - Single-clock FIFO parameterized by DATA_W and DEPTH.
  - Ports: push/wr_data, pop/rd_data (show-ahead head word), full, level.
- The top level holds the FSM, the `indata`/`vi` registers and the optional timeout.

Test Plan:
- Reset, then push 32'h000000A1. Responder acknowledges 2 cycles after vi rises and releases 2 cycles after vi falls. Expect vi=1 one cycle after the push, indata=32'h000000A1 held through REQ and REL, and level back to 0.
- Push 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444 on consecutive cycles with snt held 0. Expect the first word in `indata` and level=3. Release snt and expect all four delivered in order, busy=0 at the end.
- With DEPTH=4 and snt stuck at 0, push 6 words. Expect the 1st word in REQ, words 2-5 in the FIFO with full=1, and the 6th dropped; completing the handshakes delivers exactly words 1-5.
- Hold snt=1 through reset release, then push 32'hDEADBEEF. Expect vi to stay 0 until snt falls, then vi=1 on the following edge.
- Assert reset during REQ with level=2. Expect vi=0, indata=0 and level=0 immediately; after release no word is sent until a new push.
- With SYNC_TX_TIMEOUT_EN and TIMEOUT=64, push 1 word and never acknowledge. Expect err=1 at the 64th REQ cycle, still 1 after a late acknowledge, and cleared only by reset. Without the macro, err stays 0.
